saph_fpu_issuer: RTL and testbench

Requester-side endpoint for the shared FPU. It accepts floating-point operations from a shader core pipeline and issues them to an FPU request channel. It tracks each in-flight operation against a destination tag in a small in-order completion buffer. It returns tagged results to the core's register write-back port. Results from the FPU cannot be back-pressured, so the buffer reserves a result slot for every issued operation before that operation is issued.

---
 rtl/saph_fpu_pkg.sv | 11 +
 rtl/saph_fpu_issuer_if.sv | 52 +++++
 rtl/saph_fpu_issuer.sv | 114 +++++++++++
 tb/tb_saph_fpu_issuer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/saph_fpu_pkg.sv
// Shared FPU definitions: operation codes used by the core, issuer and FPU.
package saph_fpu_pkg;

  typedef logic [1:0] saph_fop_t;

  localparam saph_fop_t SAPH_FOP_ADD = 2'd0;
  localparam saph_fop_t SAPH_FOP_SUB = 2'd1;
  localparam saph_fop_t SAPH_FOP_MUL = 2'd2;
  localparam saph_fop_t SAPH_FOP_DIV = 2'd3;

endpackage

// File: rtl/saph_fpu_issuer_if.sv
// Bundle of the core request, FPU request/result and write-back channels.
// slave is the issuer's view; master is the environment (core + FPU) view.
interface saph_fpu_issuer_if
  import saph_fpu_pkg::*;
#(
  parameter int unsigned tag_w = 5
) ();

  logic             req_valid;
  logic             req_ready;
  saph_fop_t        req_op;
  logic [tag_w-1:0] req_tag;
  logic [31:0]      req_a;
  logic [31:0]      req_b;

  logic             fpu_valid;
  logic             fpu_ready;
  saph_fop_t        fpu_op;
  logic [31:0]      fpu_a;
  logic [31:0]      fpu_b;
  logic             fpu_res_valid;
  logic [31:0]      fpu_res;

  logic             wb_valid;
  logic             wb_ready;
  logic [tag_w-1:0] wb_tag;
  logic [31:0]      wb_data;

  logic             busy;
  logic             err_spurious;

  modport slave (
    input  req_valid, req_op, req_tag, req_a, req_b,
    output req_ready,
    output fpu_valid, fpu_op, fpu_a, fpu_b,
    input  fpu_ready, fpu_res_valid, fpu_res,
    output wb_valid, wb_tag, wb_data,
    input  wb_ready,
    output busy, err_spurious
  );

  modport master (
    output req_valid, req_op, req_tag, req_a, req_b,
    input  req_ready,
    input  fpu_valid, fpu_op, fpu_a, fpu_b,
    output fpu_ready, fpu_res_valid, fpu_res,
    input  wb_valid, wb_tag, wb_data,
    output wb_ready,
    input  busy, err_spurious
  );

endinterface

// File: rtl/saph_fpu_issuer.sv
// Requester-side FPU endpoint: issues core ops to the FPU, reserves a completion slot per
// issued op, and returns in-order tagged results through a registered write-back port.
module saph_fpu_issuer
  import saph_fpu_pkg::*;
#(
  parameter int unsigned depth = 4,
  parameter int unsigned tag_w = 5
) (
  input logic              clk,
  input logic              rst,
  saph_fpu_issuer_if.slave bus
);

  localparam int unsigned PtrW = $clog2(depth);
  localparam int unsigned CntW = PtrW + 1;

  typedef struct packed {
    logic [tag_w-1:0] tag;
    logic [31:0]      data;
    logic             done;
  } entry_t;

  entry_t           ent_q [depth];
  logic [PtrW-1:0]  alloc_ptr_q, fill_ptr_q, head_ptr_q;
  logic [CntW-1:0]  outst_q, done_cnt_q;
  logic             wb_valid_q;
  logic [tag_w-1:0] wb_tag_q;
  logic [31:0]      wb_data_q;
  logic             err_q;

  logic [CntW-1:0]  count;
  logic             full, accept, fill, spurious, retire, wb_load, cand_avail;
  logic [PtrW-1:0]  cand_ptr;
  logic [31:0]      cand_data;

  // Issue gating, event decode and selection of the next entry for the write-back register.
  always_comb begin
    count    = outst_q + done_cnt_q;
    full     = (count == CntW'(depth));
    accept   = bus.req_valid && bus.fpu_ready && !full;
    fill     = bus.fpu_res_valid && (outst_q != '0);
    spurious = bus.fpu_res_valid && (outst_q == '0);
    retire   = wb_valid_q && bus.wb_ready;
    wb_load  = !wb_valid_q || bus.wb_ready;
    // The register already holds the head, so the successor is the next candidate.
    cand_ptr   = head_ptr_q + PtrW'(wb_valid_q);
    // Bypass a result landing in the candidate entry this cycle.
    cand_avail = ent_q[cand_ptr].done || (fill && (fill_ptr_q == cand_ptr));
    cand_data  = ent_q[cand_ptr].done ? ent_q[cand_ptr].data : bus.fpu_res;
  end

  assign bus.req_ready    = bus.fpu_ready && !full;
  assign bus.fpu_valid    = bus.req_valid && !full;
  assign bus.fpu_op       = bus.req_op;
  assign bus.fpu_a        = bus.req_a;
  assign bus.fpu_b        = bus.req_b;
  assign bus.wb_valid     = wb_valid_q;
  assign bus.wb_tag       = wb_tag_q;
  assign bus.wb_data      = wb_data_q;
  assign bus.busy         = (count != '0);
  assign bus.err_spurious = err_q;

  // Completion buffer: allocate on accept, fill on result, clear done on retire.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < depth; i++) begin
        ent_q[PtrW'(i)].done <= 1'b0;
      end
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      head_ptr_q  <= '0;
      outst_q     <= '0;
      done_cnt_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      if (accept) begin
        ent_q[alloc_ptr_q].tag  <= bus.req_tag;
        ent_q[alloc_ptr_q].done <= 1'b0;
        alloc_ptr_q             <= alloc_ptr_q + PtrW'(1);
      end
      if (fill) begin
        ent_q[fill_ptr_q].data <= bus.fpu_res;
        ent_q[fill_ptr_q].done <= 1'b1;
        fill_ptr_q             <= fill_ptr_q + PtrW'(1);
      end
      // Stale done bits must not be mistaken for fresh results after wrap.
      if (retire) begin
        ent_q[head_ptr_q].done <= 1'b0;
        head_ptr_q             <= head_ptr_q + PtrW'(1);
      end
      outst_q    <= outst_q + CntW'(accept) - CntW'(fill);
      done_cnt_q <= done_cnt_q + CntW'(fill) - CntW'(retire);
      if (spurious) begin
        err_q <= 1'b1;
      end
    end
  end

  // Write-back register: reload whenever empty or being consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_q <= 1'b0;
      wb_tag_q   <= '0;
      wb_data_q  <= '0;
    end else if (wb_load) begin
      wb_valid_q <= cand_avail;
      if (cand_avail) begin
        wb_tag_q  <= ent_q[cand_ptr].tag;
        wb_data_q <= cand_data;
      end
    end
  end

endmodule

// File: tb/tb_saph_fpu_issuer.sv
// Self-checking bench for saph_fpu_issuer: directed scenarios plus randomized traffic against a
// queue-based reference model of in-order completion.
module tb_saph_fpu_issuer;
  import saph_fpu_pkg::*;

  localparam int unsigned Depth = 4;
  localparam int unsigned TagW  = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  saph_fpu_issuer_if #(.tag_w(TagW)) bus ();

  saph_fpu_issuer #(.depth(Depth), .tag_w(TagW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: tags issued but not yet answered, finished results awaiting write-back.
  logic [TagW-1:0]    pend_q[$];
  logic [TagW+31:0]   done_q[$];
  int                 exp_cnt = 0;
  logic               exp_err = 1'b0;
  // FPU model for the random phase: results with earliest return cycle.
  logic [31:0]        fq_res[$];
  int                 fq_t[$];
  bit                 rand_mode = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_step();
    logic             acc, ret;
    logic [TagW-1:0]  t;
    if (rst) begin
      pend_q.delete(); done_q.delete(); fq_res.delete(); fq_t.delete();
      exp_cnt = 0;
      exp_err = 1'b0;
      return;
    end
    acc = bus.req_valid && bus.fpu_ready && (exp_cnt < int'(Depth));
    ret = (done_q.size() != 0) && bus.wb_ready;
    chk("req_ready", 64'(bus.req_ready), 64'(bus.fpu_ready && (exp_cnt < int'(Depth))));
    chk("fpu_valid", 64'(bus.fpu_valid), 64'(bus.req_valid && (exp_cnt < int'(Depth))));
    chk("fwd_op_a", {bus.fpu_op, bus.fpu_a}, {bus.req_op, bus.req_a});
    chk("fwd_b", 64'(bus.fpu_b), 64'(bus.req_b));
    chk("busy", 64'(bus.busy), 64'(exp_cnt != 0));
    chk("err_spurious", 64'(bus.err_spurious), 64'(exp_err));
    chk("wb_valid", 64'(bus.wb_valid), 64'(done_q.size() != 0));
    if (bus.wb_valid && done_q.size() != 0) begin
      chk("wb_payload", {bus.wb_tag, bus.wb_data}, 64'(done_q[0]));
    end
    if (ret) begin
      void'(done_q.pop_front());
      exp_cnt--;
    end
    if (bus.fpu_res_valid) begin
      if (pend_q.size() != 0) begin
        t = pend_q.pop_front();
        done_q.push_back({t, bus.fpu_res});
      end else begin
        exp_err = 1'b1;
      end
    end
    if (acc) begin
      pend_q.push_back(bus.req_tag);
      exp_cnt++;
      if (rand_mode) begin
        fq_res.push_back($urandom);
        fq_t.push_back(cyc + 1 + int'($urandom_range(3, 0)));
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    bus.req_valid     = 1'b0;
    bus.req_op        = SAPH_FOP_ADD;
    bus.req_tag       = '0;
    bus.req_a         = '0;
    bus.req_b         = '0;
    bus.fpu_ready     = 1'b1;
    bus.fpu_res_valid = 1'b0;
    bus.fpu_res       = '0;
    bus.wb_ready      = 1'b1;
  endtask

  task automatic issue(input logic [TagW-1:0] tag);
    bus.req_valid = 1'b1;
    bus.req_op    = saph_fop_t'($urandom_range(3, 0));
    bus.req_tag   = tag;
    bus.req_a     = $urandom;
    bus.req_b     = $urandom;
  endtask

  task automatic result(input logic [31:0] data);
    bus.fpu_res_valid = 1'b1;
    bus.fpu_res       = data;
  endtask

  // Random FPU: returns the oldest pending result once its latency has elapsed.
  task automatic fpu_drive();
    bus.fpu_res_valid = 1'b0;
    if (fq_res.size() != 0 && fq_t[0] <= cyc && ($urandom_range(2, 0) != 0)) begin
      result(fq_res.pop_front());
      void'(fq_t.pop_front());
    end
  endtask

  initial begin
    logic [31:0] r;
    idle();
    rst = 1'b1;
    cycle();
    chk("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_err", 64'(bus.err_spurious), 64'd0);
    chk("rst_wb_data", {bus.wb_tag, bus.wb_data}, 64'd0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
    rst = 1'b0;

    // Single op: 1.0 + 2.0, FPU answers two cycles after accept.
    bus.req_valid = 1'b1; bus.req_op = SAPH_FOP_ADD; bus.req_tag = 5'd7;
    bus.req_a = 32'h3F80_0000; bus.req_b = 32'h4000_0000;
    #1 chk("single_accept", 64'(bus.req_ready), 64'd1);
    cycle();
    idle(); cycle();
    result(32'h4040_0000); cycle();
    idle();
    #1 chk("single_wb", {bus.wb_valid, bus.wb_tag, bus.wb_data}, {1'b1, 5'd7, 32'h4040_0000});
    cycle();
    #1 chk("single_busy_fall", 64'({bus.busy, bus.wb_valid}), 64'd0);

    // Fill to depth, refuse, then reopen one cycle after the first write-back.
    for (int t = 1; t <= 4; t++) begin
      issue(TagW'(t)); cycle();
    end
    issue(5'd5);
    #1 chk("fill_refuse", 64'(bus.req_ready), 64'd0);
    cycle();
    result($urandom); cycle();
    bus.fpu_res_valid = 1'b0;
    #1 chk("full_retire_tag", {bus.wb_valid, bus.wb_tag}, {1'b1, 5'd1});
    chk("full_retire_refuse", 64'(bus.req_ready), 64'd0);
    cycle();
    #1 chk("full_reopen", 64'(bus.req_ready), 64'd1);
    cycle();
    idle();
    for (int k = 0; k < 4; k++) begin
      result($urandom); cycle();
    end
    idle();
    repeat (3) cycle();
    #1 chk("fill_drained", 64'(bus.busy), 64'd0);

    // Write-back back-pressure: four results retained, then released back to back.
    bus.wb_ready = 1'b0;
    for (int t = 1; t <= 4; t++) begin
      issue(TagW'(t)); cycle();
    end
    bus.req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      result($urandom); cycle();
    end
    bus.fpu_res_valid = 1'b0;
    repeat (2) cycle();
    bus.wb_ready = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      #1 chk("bp_order", {bus.wb_valid, bus.wb_tag}, {1'b1, TagW'(t)});
      cycle();
    end
    #1 chk("bp_empty", 64'({bus.busy, bus.wb_valid}), 64'd0);

    // Spurious result with nothing outstanding.
    idle(); result(32'hDEAD_BEEF); cycle();
    idle();
    #1 chk("spur_set", {bus.err_spurious, bus.wb_valid}, 64'b10);
    repeat (2) cycle();
    #1 chk("spur_hold", 64'(bus.err_spurious), 64'd1);
    rst = 1'b1; cycle(); rst = 1'b0;
    #1 chk("spur_clear", 64'(bus.err_spurious), 64'd0);

    // Reset with three ops in flight, then a clean op.
    for (int t = 10; t <= 12; t++) begin
      issue(TagW'(t)); cycle();
    end
    idle(); rst = 1'b1; cycle(); rst = 1'b0;
    #1 chk("mid_rst_idle", 64'({bus.busy, bus.wb_valid}), 64'd0);
    issue(5'd9); cycle();
    idle(); r = $urandom; result(r); cycle();
    idle();
    #1 chk("post_rst_wb", {bus.wb_valid, bus.wb_tag, bus.wb_data}, {1'b1, 5'd9, r});
    cycle();

    // Randomized traffic.
    rand_mode = 1'b1;
    fq_res.delete(); fq_t.delete();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3, 0) != 0) issue(TagW'($urandom)); else bus.req_valid = 1'b0;
      bus.fpu_ready = ($urandom_range(3, 0) != 0);
      bus.wb_ready  = ($urandom_range(9, 0) < 7);
      fpu_drive();
      cycle();
    end
    bus.req_valid = 1'b0;
    bus.wb_ready  = 1'b1;
    for (int i = 0; i < 300 && (exp_cnt != 0 || fq_res.size() != 0); i++) begin
      fpu_drive();
      cycle();
    end
    bus.fpu_res_valid = 1'b0;
    #1 chk("drain_busy", 64'(bus.busy), 64'd0);
    chk("drain_model_empty", 64'(exp_cnt), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
